// File: rtl/core_pkg.sv
// Shared definitions for the single-issue core front end.
// Holds the RV32I base opcodes and the immediate-format enumeration that
// the decode stage and the immediate generator both use.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: classifies an instruction word by opcode into one of
// the RV32I encoding formats and produces the sign-extended immediate.
// Ports:
//   inst        in   32    instruction word
//   imm         out  XLEN  immediate, sign-extended to XLEN (0 for R and unknown)
//   fmt         out  fmt_e encoding format of inst
//   bad_opcode  out  1     opcode is not an RV32I base opcode
module imm_gen
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            bad_opcode
);

  logic signed [31:0] imm32;

  // NOTE: combinational processes assign every output a default first so no
  // path leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    fmt = FMT_BAD;
    unique case (inst[6:0])
      OP_R:                               fmt = FMT_R;
      OP_I, OP_LOAD, OP_JALR, OP_SYSTEM:  fmt = FMT_I;
      OP_STORE:                           fmt = FMT_S;
      OP_BRANCH:                          fmt = FMT_B;
      OP_JAL:                             fmt = FMT_J;
      OP_LUI, OP_AUIPC:                   fmt = FMT_U;
      default:                            fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_U: imm32 = {inst[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed size cast sign-extends the 32-bit immediate to the datapath width.
  assign imm        = XLEN'(imm32);
  assign bad_opcode = (fmt == FMT_BAD);

endmodule

// File: rtl/decode_regfile_stage.sv
// Decode / register-file stage of the single-issue core.
// Holds the architectural register file, reads operands for the presented
// instruction (with write-back bypass), decodes the immediate, and registers
// the result into a one-entry ID/EX buffer with valid/ready handshake.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            fetch-side handshake
//   in_pc, in_inst               presented instruction
//   wb_en, wb_rd, wb_data        write-back port into the register file
//   flush                        drop held and incoming instruction
//   out_valid/out_ready          execute-side handshake
//   out_pc .. out_illegal        buffered decode results
//   dbg_addr, dbg_data           combinational debug read (with bypass)
module decode_regfile_stage
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic            out_illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int IDXW = $clog2(NREGS);

  function automatic logic in_range(input logic [4:0] idx);
    return int'(idx) < NREGS;
  endfunction

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wb_hit;

  assign wb_hit = wb_en && (wb_rd != 5'd0) && in_range(wb_rd);

  always_comb begin
    regs_d = regs_q;
    if (wb_hit) regs_d[wb_rd[IDXW-1:0]] = wb_data;
  end

  // NOTE: the array is reset because software relies on every register
  // reading zero after reset; this forces it into flops rather than RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // Read with write-back bypass: x0 and nonexistent registers read zero, and a
  // write landing this cycle is visible immediately.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
    logic [XLEN-1:0] val;
    val = '0;
    if (idx != 5'd0 && in_range(idx)) begin
      if (wb_hit && wb_rd == idx) val = wb_data;
      else                        val = regs_q[idx[IDXW-1:0]];
    end
    return val;
  endfunction

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic [4:0]      rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] dec_imm, rs1_rd_data, rs2_rd_data;
  fmt_e            dec_fmt;
  logic            dec_bad_opcode;
  logic            use_rs1, use_rs2, use_rd;
  logic            dec_illegal;

  assign rs1_idx = in_inst[19:15];
  assign rs2_idx = in_inst[24:20];
  assign rd_idx  = in_inst[11:7];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst       (in_inst),
    .imm        (dec_imm),
    .fmt        (dec_fmt),
    .bad_opcode (dec_bad_opcode)
  );

  always_comb begin
    rs1_rd_data = read_port(rs1_idx);
    rs2_rd_data = read_port(rs2_idx);
    dbg_data    = read_port(dbg_addr);
  end

  // Only fields the format actually encodes as registers can make an
  // instruction illegal on a reduced register file.
  assign use_rs1 = dec_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
  assign use_rs2 = dec_fmt inside {FMT_R, FMT_S, FMT_B};
  assign use_rd  = dec_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};

  assign dec_illegal = dec_bad_opcode
                     | (use_rs1 & ~in_range(rs1_idx))
                     | (use_rs2 & ~in_range(rs2_idx))
                     | (use_rd  & ~in_range(rd_idx));

  // ---------------------------------------------------------------------
  // ID/EX buffer
  // ---------------------------------------------------------------------
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      rd_q, rd_d;
  logic [6:0]      opcode_q, opcode_d;
  logic            illegal_q, illegal_d;
  logic [4:0]      rs1_idx_q, rs1_idx_d;
  logic [4:0]      rs2_idx_q, rs2_idx_d;
  logic            accept;

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    opcode_d   = opcode_q;
    illegal_d  = illegal_q;
    rs1_idx_d  = rs1_idx_q;
    rs2_idx_d  = rs2_idx_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      pc_d       = in_pc;
      rs1_data_d = rs1_rd_data;
      rs2_data_d = rs2_rd_data;
      imm_d      = dec_imm;
      rd_d       = rd_idx;
      opcode_d   = in_inst[6:0];
      illegal_d  = dec_illegal;
      rs1_idx_d  = rs1_idx;
      rs2_idx_d  = rs2_idx;
    end else if (valid_q && !out_ready) begin
      // Stalled: keep operands coherent with write-backs that arrive while
      // the entry waits, so execute never sees a stale value.
      if (wb_hit && wb_rd == rs1_idx_q) rs1_data_d = wb_data;
      if (wb_hit && wb_rd == rs2_idx_q) rs2_data_d = wb_data;
    end else begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      opcode_q   <= '0;
      illegal_q  <= 1'b0;
      rs1_idx_q  <= '0;
      rs2_idx_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      opcode_q   <= opcode_d;
      illegal_q  <= illegal_d;
      rs1_idx_q  <= rs1_idx_d;
      rs2_idx_q  <= rs2_idx_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_rs1_data = rs1_data_q;
  assign out_rs2_data = rs2_data_q;
  assign out_imm      = imm_q;
  assign out_rd       = rd_q;
  assign out_opcode   = opcode_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_regfile_stage.sv
// Directed bench for decode_regfile_stage. Two instances share all inputs:
// the RV32I configuration (NREGS=32) and an RV32E one (NREGS=16).
module tb_decode_regfile_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_ready;
  logic [4:0]  dbg_addr;

  logic        a_in_ready, a_valid, a_illegal;
  logic [31:0] a_pc, a_rs1, a_rs2, a_imm, a_dbg;
  logic [4:0]  a_rd;
  logic [6:0]  a_opcode;

  logic        e_in_ready, e_valid, e_illegal;
  logic [31:0] e_pc, e_rs1, e_rs2, e_imm, e_dbg;
  logic [4:0]  e_rd;
  logic [6:0]  e_opcode;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decode_regfile_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(a_valid), .out_ready(out_ready), .out_pc(a_pc),
    .out_rs1_data(a_rs1), .out_rs2_data(a_rs2), .out_imm(a_imm),
    .out_rd(a_rd), .out_opcode(a_opcode), .out_illegal(a_illegal),
    .dbg_addr(dbg_addr), .dbg_data(a_dbg)
  );

  decode_regfile_stage #(.XLEN(32), .NREGS(16)) dut_e (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(e_in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(e_valid), .out_ready(out_ready), .out_pc(e_pc),
    .out_rs1_data(e_rs1), .out_rs2_data(e_rs2), .out_imm(e_imm),
    .out_rd(e_rd), .out_opcode(e_opcode), .out_illegal(e_illegal),
    .dbg_addr(dbg_addr), .dbg_data(e_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
  endtask

  task automatic write_back(input logic [4:0] rd, input logic [31:0] data);
    wb_en   = 1'b1;
    wb_rd   = rd;
    wb_data = data;
  endtask

  logic [31:0] exp_e;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
    out_ready = 1'b1; dbg_addr = '0;

    // Reset state
    #12;
    check("rst_valid",    a_valid,    32'd0);
    check("rst_pc",       a_pc,       32'd0);
    check("rst_imm",      a_imm,      32'd0);
    check("rst_rd",       a_rd,       32'd0);
    check("rst_opcode",   a_opcode,   32'd0);
    check("rst_illegal",  a_illegal,  32'd0);
    check("rst_in_ready", a_in_ready, 32'd1);
    @(negedge clk) rst = 1'b0;

    // Write x5 then read it back through the debug port
    write_back(5'd5, 32'hDEADBEEF);
    dbg_addr = 5'd5;
    #1 check("dbg_bypass_x5", a_dbg, 32'hDEADBEEF);
    tick();
    wb_en = 1'b0;
    #1 check("dbg_x5", a_dbg, 32'hDEADBEEF);

    // add x1,x5,x0
    present(32'h100, 32'h000280B3);
    tick();
    in_valid = 1'b0;
    check("add_valid",  a_valid,   32'd1);
    check("add_pc",     a_pc,      32'h100);
    check("add_rs1",    a_rs1,     32'hDEADBEEF);
    check("add_rs2",    a_rs2,     32'd0);
    check("add_imm",    a_imm,     32'd0);
    check("add_rd",     a_rd,      32'd1);
    check("add_opcode", a_opcode,  32'h33);
    check("add_illegal",a_illegal, 32'd0);

    // Write to x0 is ignored; entry consumed with nothing behind it
    write_back(5'd0, 32'h1234);
    dbg_addr = 5'd0;
    tick();
    wb_en = 1'b0;
    #1 check("dbg_x0", a_dbg, 32'd0);
    check("consumed_valid", a_valid, 32'd0);

    // addi x2,x5,-1 accepted alongside wb x5=7 -> bypass
    present(32'h104, 32'hFFF28113);
    write_back(5'd5, 32'd7);
    out_ready = 1'b0;
    tick();
    check("addi_rs1_bypass", a_rs1, 32'd7);
    check("addi_imm",        a_imm, 32'hFFFFFFFF);
    check("addi_rd",         a_rd,  32'd2);
    check("addi_rs2",        a_rs2, 32'd0);

    // Stall: lui presented but not taken, wb x5=9 refreshes held rs1
    present(32'h108, 32'h123451B7);
    write_back(5'd5, 32'd9);
    #1 check("stall_in_ready", a_in_ready, 32'd0);
    tick();
    wb_en = 1'b0;
    check("refresh_valid",  a_valid,  32'd1);
    check("refresh_rs1",    a_rs1,    32'd9);
    check("refresh_rs2",    a_rs2,    32'd0);
    check("refresh_pc",     a_pc,     32'h104);
    check("refresh_imm",    a_imm,    32'hFFFFFFFF);
    check("refresh_rd",     a_rd,     32'd2);
    check("refresh_opcode", a_opcode, 32'h13);

    // Back-to-back accepts, one per cycle, exercising every immediate format
    out_ready = 1'b1;
    tick();
    check("lui_valid", a_valid, 32'd1);
    check("lui_pc",    a_pc,    32'h108);
    check("lui_imm",   a_imm,   32'h12345000);
    check("lui_rd",    a_rd,    32'd3);
    present(32'h10C, 32'hFFDFF0EF);
    tick();
    check("jal_valid", a_valid, 32'd1);
    check("jal_pc",    a_pc,    32'h10C);
    check("jal_imm",   a_imm,   32'hFFFFFFFC);
    check("jal_rd",    a_rd,    32'd1);
    present(32'h110, 32'h00000463);
    tick();
    check("beq_valid",  a_valid,  32'd1);
    check("beq_imm",    a_imm,    32'h8);
    check("beq_opcode", a_opcode, 32'h63);
    present(32'h114, 32'hFE512C23);
    tick();
    check("sw_valid", a_valid, 32'd1);
    check("sw_imm",   a_imm,   32'hFFFFFFF8);
    check("sw_rs1",   a_rs1,   32'd0);
    check("sw_rs2",   a_rs2,   32'd9);
    present(32'h118, 32'h0000007F);
    tick();
    in_valid = 1'b0;
    check("bad_valid",   a_valid,   32'd1);
    check("bad_pc",      a_pc,      32'h118);
    check("bad_illegal", a_illegal, 32'd1);
    check("bad_imm",     a_imm,     32'd0);

    // Flush discards an incoming instruction; the write-back still commits
    present(32'h200, 32'h000280B3);
    flush = 1'b1;
    write_back(5'd6, 32'h55);
    tick();
    flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    check("flush_valid", a_valid, 32'd0);
    dbg_addr = 5'd6;
    #1 check("flush_wb_x6", a_dbg, 32'h55);
    tick();
    check("flush_lost", a_valid, 32'd0);

    // Flush wins over a stalled entry
    out_ready = 1'b0;
    present(32'h300, 32'h000280B3);
    tick();
    in_valid = 1'b0;
    check("held_valid", a_valid, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_stall_valid", a_valid, 32'd0);

    // RV32E: x20 destination and x17 source are out of range
    out_ready = 1'b1;
    present(32'h400, 32'h00208A33);
    tick();
    check("e_rd20_valid",   e_valid,   32'd1);
    check("e_rd20_illegal", e_illegal, 32'd1);
    check("i_rd20_illegal", a_illegal, 32'd0);
    present(32'h404, 32'h000880B3);
    tick();
    in_valid = 1'b0;
    check("e_rs17_illegal", e_illegal, 32'd1);
    check("e_rs17_rs1",     e_rs1,     32'd0);
    check("i_rs17_illegal", a_illegal, 32'd0);

    write_back(5'd17, 32'hAAAA);
    tick();
    wb_en = 1'b0;
    dbg_addr = 5'd17;
    #1;
    check("i_x17", a_dbg, 32'hAAAA);
    check("e_x17", e_dbg, 32'd0);
    for (int i = 1; i < 16; i++) begin
      dbg_addr = 5'(i);
      #1;
      exp_e = (i == 5) ? 32'd9 : (i == 6) ? 32'h55 : 32'd0;
      check($sformatf("e_reg%0d", i), e_dbg, exp_e);
    end

    // Asynchronous reset mid-cycle while an entry is held
    out_ready = 1'b0;
    present(32'h500, 32'h000280B3);
    tick();
    in_valid = 1'b0;
    check("pre_rst_valid", a_valid, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid",   a_valid, 32'd0);
    check("async_rst_e_valid", e_valid, 32'd0);
    check("async_rst_pc",      a_pc,    32'd0);
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("post_rst_i_x%0d", i), a_dbg, 32'd0);
      check($sformatf("post_rst_e_x%0d", i), e_dbg, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_regfile_stage.md
Name: decode_regfile_stage

Overview:
Parametrised successor of the register-file/immediate decode block for the single-issue core.
- Holds the architectural register file (depth and width configurable) and generates immediates for all RV32I formats, including U-type.
- Registers its outputs into a one-entry ID/EX pipeline buffer with valid/ready handshake, write-back bypass, stall-time operand refresh, flush and an illegal-instruction flag.

Parameters:
XLEN, 32, datapath and register width; immediates sign-extend to XLEN.
NREGS, 32, number of architectural registers (32 = RV32I, 16 = RV32E); legal values 16 or 32.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept this cycle
in_pc  input  XLEN  PC of presented instruction
in_inst  input  32  instruction word
wb_en  input  1  write-back strobe
wb_rd  input  5  write-back destination index
wb_data  input  XLEN  write-back value
flush  input  1  discard held and incoming instruction
out_valid  output  1  buffered entry valid
out_ready  input  1  execute consumes entry
out_pc  output  XLEN  buffered PC
out_rs1_data  output  XLEN  operand 1
out_rs2_data  output  XLEN  operand 2
out_imm  output  XLEN  decoded immediate
out_rd  output  5  destination index
out_opcode  output  7  inst[6:0]
out_illegal  output  1  unknown opcode or register index >= NREGS
dbg_addr  input  5  debug read index (board display)
dbg_data  output  XLEN  combinational read of register dbg_addr

Behaviour:
- Reset (async, rst=1): all NREGS registers = 0; out_valid = 0; out_pc, out_rs1_data, out_rs2_data, out_imm = 0; out_rd = 0; out_opcode = 0; out_illegal = 0. State is held while rst is high. Reset mid-handshake drops the held entry.
- Register write: on a clock edge with wb_en=1, wb_rd != 0 and wb_rd < NREGS, registers[wb_rd] <= wb_data. A write to x0 or an out-of-range index is ignored.
- Read: index 0 or index >= NREGS reads 0.
- Bypass: if wb_en=1 in the accept cycle and wb_rd == rs (nonzero, in range), the captured operand is wb_data, not the stale array value. dbg_data uses the same bypass.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational; flush does not affect it).
  - Accept = in_valid & in_ready. Latency is 1 cycle: fields appear on outputs the edge after accept.
- Stall refresh: while out_valid=1 and out_ready=0, a write-back to the held entry's rs1/rs2 (nonzero, in range) updates out_rs1_data/out_rs2_data on that edge. All other held fields are stable.
- Flush: on an edge with flush=1, out_valid <= 0 and any simultaneous accept is discarded. Register writes still occur. Flush has priority over accept and over stall.
- Simultaneous consume + accept (out_valid=1, out_ready=1, in_valid=1): the new entry replaces the old one on the same edge with no bubble.
- Immediate (opcode = inst[6:0]):
  - R 0110011 -> 0.
  - I 0010011/0000011/1100111/1110011 -> sext(inst[31:20]).
  - S 0100011 -> sext({inst[31:25],inst[11:7]}).
  - B 1100011 -> sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - J 1101111 -> sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - U 0110111/0010111 -> sext({inst[31:12],12'b0}).
  - Any other opcode -> imm 0 and out_illegal=1.
- out_illegal is also set when any used index (rs1, rs2, rd) >= NREGS. Used indices per format: rs1 for R/I/S/B; rs2 for R/S/B; rd for R/I/U/J.
- Illegal entries still flow through the handshake; execute traps on them.

Decomposition:
- Shared package core_pkg holds the opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM) and the immediate-format enum (FMT_R/I/S/B/U/J/BAD).
- One combinational sub-module, imm_gen (inst -> imm, fmt, bad_opcode), parametrised by XLEN.
- The register array and the pipeline buffer stay in the top module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle while out_valid=1 -> out_valid drops immediately, dbg_data reads 0 for every index after release.
- Write then read: wb_en=1, wb_rd=5, wb_data=0xDEADBEEF; next cycle accept `add x1,x5,x0` -> out_rs1_data=0xDEADBEEF, out_rs2_data=0, out_imm=0. A write of 0x1234 to x0 -> dbg_addr=0 reads 0.
- Bypass and refresh:
  - Accept `addi x2,x5,-1` (0xFFF28113) in the same cycle as wb x5=7 -> out_rs1_data=7, out_imm=0xFFFFFFFF.
  - Hold out_ready=0, then wb x5=9 -> out_rs1_data becomes 9, all other fields unchanged.
- Immediates:
  - `lui x3,0x12345` (0x123451B7) -> out_imm=0x12345000.
  - `jal x1,-4` (0xFFDFF0EF) -> 0xFFFFFFFC.
  - `beq x0,x0,+8` (0x00000463) -> 0x00000008.
  - `sw x5,-8(x2)` (0xFE512C23) -> 0xFFFFFFF8.
  - Opcode 0x7F -> out_illegal=1, imm 0.
- Handshake and flush:
  - Back-to-back accepts with out_ready=1 -> one output per cycle, no bubble.
  - flush=1 with in_valid=1 -> next cycle out_valid=0 and the instruction is lost; a wb in the same cycle still commits.
- RV32E: NREGS=16, accept `add x20,x1,x2` -> out_illegal=1; wb_rd=17 leaves all registers unchanged.
